// File: rtl/ntt_sdf_reorder_pkg.sv
// ----------------------------------------------------------------------------
// ntt_sdf_reorder_pkg
//   Shared NTT parameter helpers used by the SDF output reorder buffer.
//   ntt_n       : frame length N = 2**logn
//   ntt_bank_aw : address width of a two-bank (ping-pong) buffer, {bank, offset}
// ----------------------------------------------------------------------------
package ntt_sdf_reorder_pkg;

   function automatic int unsigned ntt_n(input int unsigned logn);
      return 32'd1 << logn;
   endfunction

   function automatic int unsigned ntt_bank_aw(input int unsigned logn);
      return logn + 32'd1;
   endfunction

endpackage

// File: rtl/bitreverse.sv
// ----------------------------------------------------------------------------
// bitreverse
//   Combinational bit-order reversal: o_data[i] = i_data[WIDTH-1-i].
//   i_data : input word
//   o_data : bit-reversed word
// ----------------------------------------------------------------------------
module bitreverse #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   always_comb begin
      o_data = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         o_data[i] = i_data[WIDTH-1-i];
      end
   end

endmodule

// File: rtl/ntt_reorder_ram.sv
// ----------------------------------------------------------------------------
// ntt_reorder_ram
//   Simple dual-port memory, depth 2N (two banks of N), width LOGQ.
//   Read data appears DELAY cycles after i_re/i_raddr are presented.
//   Contents are not reset.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address {bank, offset}
//   i_wdata : write data
//   i_re    : read enable
//   i_raddr : read address {bank, offset}
//   o_rdata : read data (DELAY-cycle latency)
// ----------------------------------------------------------------------------
module ntt_reorder_ram
   import ntt_sdf_reorder_pkg::*;
#(
   parameter int unsigned LOGQ  = 64,
   parameter int unsigned LOGN  = 10,
   parameter int unsigned DELAY = 1
) (
   input  logic                         clk,
   input  logic                         i_we,
   input  logic [ntt_bank_aw(LOGN)-1:0] i_waddr,
   input  logic [LOGQ-1:0]              i_wdata,
   input  logic                         i_re,
   input  logic [ntt_bank_aw(LOGN)-1:0] i_raddr,
   output logic [LOGQ-1:0]              o_rdata
);

   localparam int unsigned DEPTH = 2 * ntt_n(LOGN);

   logic [LOGQ-1:0] r_mem [DEPTH];
   logic [LOGQ-1:0] r_rd0;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
         r_rd0 <= r_mem[i_raddr];
      end
   end

   if (DELAY == 1) begin : g_lat1
      assign o_rdata = r_rd0;
   end else begin : g_lat2
      logic [LOGQ-1:0] r_rd1;
      always_ff @(posedge clk) begin
         r_rd1 <= r_rd0;
      end
      assign o_rdata = r_rd1;
   end

endmodule

// File: rtl/ntt_sdf_reorder.sv
// ----------------------------------------------------------------------------
// ntt_sdf_reorder
//   Output reorder buffer for the last SDF NTT stage. Coefficients arrive in
//   bit-reversed order and are written at bitreverse(wcnt) of the write bank
//   (or at wcnt when the frame's bypass flag is set). When a frame completes
//   the banks swap and the read FSM drains the full bank in natural order.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : din valid this cycle
//   din        : coefficient, bit-reversed order
//   bypass     : frame written in natural order (sampled on word 0)
//   dout       : reordered coefficient, 0 when not valid
//   dout_valid : dout valid
//   dout_last  : word N-1 of a frame (qualified by dout_valid)
//   busy       : frame partially written, draining, or reads in flight
// ----------------------------------------------------------------------------
module ntt_sdf_reorder
   import ntt_sdf_reorder_pkg::*;
#(
   parameter int unsigned LOGQ       = 64,
   parameter int unsigned LOGN       = 10,
   parameter int unsigned DELAY_BRAM = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LOGQ-1:0] din,
   input  logic            bypass,
   output logic [LOGQ-1:0] dout,
   output logic            dout_valid,
   output logic            dout_last,
   output logic            busy
);

   localparam int unsigned AW = ntt_bank_aw(LOGN);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } rd_state_t;

   logic [LOGN-1:0]       r_wcnt;
   logic                  r_wbank;
   logic                  r_bypass;
   logic [LOGN-1:0]       w_wcnt_rev;
   logic [LOGN-1:0]       w_waddr_off;
   logic                  w_byp;
   logic                  w_trig;

   rd_state_t             r_state;
   rd_state_t             w_state_nxt;
   logic [LOGN-1:0]       r_raddr;
   logic                  w_rd_en;
   logic                  w_rd_last;

   logic [DELAY_BRAM-1:0] r_vld_pipe;
   logic [DELAY_BRAM-1:0] r_last_pipe;

   logic [AW-1:0]         w_ram_waddr;
   logic [AW-1:0]         w_ram_raddr;
   logic [LOGQ-1:0]       w_rdata;

   // ---------------- write side ----------------
   bitreverse #(
      .WIDTH (LOGN)
   ) u_bitrev (
      .i_data (r_wcnt),
      .o_data (w_wcnt_rev)
   );

   // Word 0 uses the live bypass input; later words use the value latched
   // with word 0, so a mid-frame change on bypass has no effect.
   assign w_byp       = (r_wcnt == '0) ? bypass : r_bypass;
   assign w_waddr_off = w_byp ? r_wcnt : w_wcnt_rev;
   assign w_trig      = start && (&r_wcnt);
   assign w_ram_waddr = {r_wbank, w_waddr_off};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wcnt   <= '0;
         r_wbank  <= 1'b0;
         r_bypass <= 1'b0;
      end else if (start) begin
         r_wcnt <= r_wcnt + 1'b1;
         if (r_wcnt == '0) begin
            r_bypass <= bypass;
         end
         if (w_trig) begin
            r_wbank <= ~r_wbank;
         end
      end
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_raddr <= '0;
      end else begin
         r_state <= w_state_nxt;
         // Natural wrap from N-1 to 0 lets a same-cycle trigger restart cleanly.
         if (w_rd_en) begin
            r_raddr <= r_raddr + 1'b1;
         end else begin
            r_raddr <= '0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_rd_last   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_trig) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            w_rd_en   = 1'b1;
            w_rd_last = &r_raddr;
            if (w_rd_last && !w_trig) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Read bank is always the one not being written.
   assign w_ram_raddr = {~r_wbank, r_raddr};

   ntt_reorder_ram #(
      .LOGQ  (LOGQ),
      .LOGN  (LOGN),
      .DELAY (DELAY_BRAM)
   ) u_ram (
      .clk     (clk),
      .i_we    (start),
      .i_waddr (w_ram_waddr),
      .i_wdata (din),
      .i_re    (w_rd_en),
      .i_raddr (w_ram_raddr),
      .o_rdata (w_rdata)
   );

   // ---------------- read-latency tracking ----------------
   if (DELAY_BRAM == 1) begin : g_pipe1
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
         end else begin
            r_vld_pipe  <= w_rd_en;
            r_last_pipe <= w_rd_last;
         end
      end
   end else begin : g_pipen
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
         end else begin
            r_vld_pipe  <= {r_vld_pipe[DELAY_BRAM-2:0], w_rd_en};
            r_last_pipe <= {r_last_pipe[DELAY_BRAM-2:0], w_rd_last};
         end
      end
   end

   assign dout_valid = r_vld_pipe[DELAY_BRAM-1];
   assign dout_last  = r_last_pipe[DELAY_BRAM-1] & dout_valid;
   assign dout       = dout_valid ? w_rdata : '0;
   assign busy       = (r_wcnt != '0) || w_rd_en || (|r_vld_pipe);

endmodule

// File: doc/ntt_sdf_reorder.md
NTT_SDF_REORDER -- requirements
Module: ntt_sdf_reorder

Interface
REQ-001 SHALL have parameter LOGQ, default 64: coefficient width in bits.
REQ-002 SHALL have parameter LOGN, default 10: log2 of frame length N.
REQ-003 SHALL have parameter DELAY_BRAM, default 1: buffer read latency in cycles, range 1..2.
REQ-004 SHALL have port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1: din valid this cycle; driven by the finish of the last SDF stage.
REQ-007 SHALL have port din  input  LOGQ: coefficient from the last SDF stage, in bit-reversed order.
REQ-008 SHALL have port bypass  input  1: 1 writes in natural order, with no reordering.
REQ-009 SHALL have port dout  output  LOGQ: reordered coefficient.
REQ-010 SHALL have port dout_valid  output  1: dout is valid this cycle.
REQ-011 SHALL have port dout_last  output  1: marks word N-1 of a frame; qualified by dout_valid.
REQ-012 SHALL have port busy  output  1: a frame is partially written or is draining.

Function
REQ-013 SHALL hold two banks of N words each, used ping-pong; the write bank and the read bank are always different.
REQ-014 SHALL keep a write counter wcnt[LOGN-1:0], which increments on each start cycle; cycles without start are gaps and are allowed.
REQ-015 SHALL write din at address bitreverse(wcnt) of the write bank, or at address wcnt when bypass is 1.
REQ-016 SHALL sample bypass only when wcnt==0 and start is high; the sampled value holds for the whole frame.
REQ-017 SHALL end a frame on the start cycle with wcnt==N-1: wcnt wraps to 0, the banks swap on the next edge, and a drain is triggered.
REQ-018 SHALL implement the read FSM with states IDLE and DRAIN:
- IDLE -> DRAIN on a drain trigger.
- DRAIN reads addresses 0..N-1 of the read bank, one per cycle with no gaps.
- DRAIN -> IDLE after address N-1 is issued.
REQ-019 SHALL assert dout_valid exactly DELAY_BRAM cycles after each read address is issued.
- The first dout_valid falls 1+DELAY_BRAM cycles after the last start of the frame.
REQ-020 SHALL assert dout_last together with the dout_valid of address N-1.
REQ-021 SHALL drive dout to 0 whenever dout_valid is 0.
REQ-022 SHALL support back-to-back frames.
- A frame ends no earlier than N cycles after the previous one, so a drain always completes before the next swap.
- A new trigger arriving in the same cycle DRAIN issues address N-1 SHALL re-enter DRAIN without an idle cycle.
REQ-023 SHALL set busy to (wcnt!=0) OR (state==DRAIN) OR (any read pending in the DELAY_BRAM pipeline).
REQ-024 SHALL be lossless and value-preserving: no arithmetic is performed on din.

Reset
REQ-025 SHALL, while rst is low, force wcnt=0, write bank=0, state=IDLE, and all pipeline valids to 0.
REQ-026 SHALL, while rst is low, force dout=0, dout_valid=0, dout_last=0 and busy=0.
REQ-027 SHALL discard partial frames on a reset mid-operation; the first start after rst is released is word 0 of a new frame.
REQ-028 SHALL leave memory contents unreset.

Structure
REQ-029 SHALL place the helper functions for N=2**LOGN and the bank-address width in the shared NTT parameter package; no new typedefs are needed.
REQ-030 SHALL reuse the existing bitreverse sub-module with width LOGN.
REQ-031 SHALL instantiate exactly one new sub-module, ntt_reorder_ram:
- simple dual-port memory of depth 2N and width LOGQ;
- read latency DELAY_BRAM;
- address is {bank, offset}.

Verification
REQ-032 SHALL check, with LOGN=3 and DELAY_BRAM=1: din=0..7 on 8 consecutive start cycles with bypass=0 -> dout=0,4,2,6,1,5,3,7, the first value 2 cycles after the last start, and dout_last on the value 7.
REQ-033 SHALL check the same stimulus with bypass=1 -> dout=0..7 in natural order.
REQ-034 SHALL check two back-to-back frames (din 0..7 then 8..15, start high continuously) -> 16 contiguous valid outputs 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15.
REQ-035 SHALL check frame 0..7 with start low for 3 cycles after word 4 -> output identical to REQ-032 and timed from the last start.
REQ-036 SHALL check rst low after word 5, then a fresh frame 0..7 -> no output from the aborted frame; the fresh frame reorders correctly; busy=0 during reset.
REQ-037 SHALL check DELAY_BRAM=2, LOGN=4, din=0..15 -> dout = bitreverse4(k) for k=0..15, with the first value 3 cycles after the last start.
